sorted_list_scheduler: RTL and testbench

- Owns the table state for N_LISTS independent 4-entry sorted lists and shares the single 3-stage sorting_network between N_REQ insert requesters.
- Each accepted insert does a read-modify-write on one list:
  - read the list;
  - replace entry 3 (the smallest) with the new entry;
  - send the result through sorting_network;
  - write the sorted result back.
- Arbitration is round-robin, with per-list hazard blocking.
- A separate query port returns the current state of any list.

---
 rtl/sorted_lists_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/sorted_list_scheduler.sv | 104 ++++++++++
 tb/tb_sorted_list_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sorted_lists_pkg.sv
// Shared types and sizing for the sorted-list scheduler slice.
package sorted_lists_pkg;

   localparam int unsigned N_LISTS = 4;
   localparam int unsigned N_REQ   = 2;
   localparam int unsigned SN_LAT  = 3;
   localparam int unsigned LIST_W  = $clog2(N_LISTS);

   typedef logic [7:0] key_t;
   typedef logic [7:0] value_t;

   typedef struct packed {
      key_t   key;
      value_t value;
   } entry_t;

   // e[0] holds the largest key, e[3] the smallest; key 0 marks an empty slot
   typedef struct packed {
      entry_t [0:3] e;
   } table_state_t;

   typedef logic [LIST_W-1:0] list_id_t;

   typedef struct packed {
      logic     vld;
      list_id_t id;
   } inflight_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter; pointer moves past the winner on a grant.
module rr_arbiter #(
   parameter int unsigned N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic          found;

   // first requester at or after the pointer wins, then wrap to the low indices
   always_comb begin
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && req[i] && (i >= 32'(ptr_q))) begin
            found  = 1'b1;
            gnt[i] = 1'b1;
            ptr_d  = (i == N - 1) ? '0 : PW'(i + 1);
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            found  = 1'b1;
            gnt[i] = 1'b1;
            ptr_d  = (i == N - 1) ? '0 : PW'(i + 1);
         end
      end
   end

   // pointer register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/sorted_list_scheduler.sv
// Owns N_LISTS sorted lists and shares one external sorting network between
// N_REQ insert requesters via read-modify-write with per-list hazard blocking.
module sorted_list_scheduler
   import sorted_lists_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic     [N_REQ-1:0]     req_valid,
   output logic     [N_REQ-1:0]     req_ready,
   input  list_id_t [N_REQ-1:0]     req_list_id,
   input  entry_t   [N_REQ-1:0]     req_entry,
   output logic                     sn_unsorted_valid,
   output table_state_t             sn_unsorted,
   input  table_state_t             sn_sorted_r,
   input  logic                     qry_valid,
   input  list_id_t                 qry_list_id,
   output logic                     qry_resp_valid,
   output table_state_t             qry_resp,
   output logic                     busy
);

   localparam int unsigned RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   table_state_t                tbl_q [N_LISTS];
   table_state_t                tbl_d [N_LISTS];
   inflight_tag_t [SN_LAT:1]    tag_q, tag_d;
   logic                        qry_resp_valid_q, qry_resp_valid_d;
   table_state_t                qry_resp_q, qry_resp_d;

   logic [N_REQ-1:0] elig, gnt;
   logic [RW-1:0]    gidx;
   logic             issue;
   logic             blk;

   // a requester is eligible unless its list has an op anywhere in the tag pipe
   always_comb begin
      elig = '0;
      blk  = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         blk = 1'b0;
         for (int unsigned k = 1; k <= SN_LAT; k++) begin
            if (tag_q[k].vld && (tag_q[k].id == req_list_id[i])) blk = 1'b1;
         end
         elig[i] = req_valid[i] & ~blk;
      end
   end

   rr_arbiter #(.N(N_REQ)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (elig),
      .gnt (gnt)
   );

   // grant encode and build the modified list for the sorting network
   always_comb begin
      req_ready = rst ? '0 : gnt;
      gidx      = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (req_ready[i]) gidx = RW'(i);
      end
      issue             = |req_ready;
      sn_unsorted_valid = issue;
      sn_unsorted       = tbl_q[req_list_id[gidx]];
      // a new key not above the current minimum keeps the old e[3], so the
      // sorted writeback leaves the list unchanged
      if (req_entry[gidx].key > sn_unsorted.e[3].key) sn_unsorted.e[3] = req_entry[gidx];
   end

   // tag pipe advance, writeback from stage SN_LAT, query with writeback bypass
   always_comb begin
      tag_d[1] = {issue, req_list_id[gidx]};
      for (int unsigned k = 2; k <= SN_LAT; k++) tag_d[k] = tag_q[k-1];
      tbl_d = tbl_q;
      if (tag_q[SN_LAT].vld) tbl_d[tag_q[SN_LAT].id] = sn_sorted_r;
      qry_resp_valid_d = qry_valid;
      qry_resp_d       = tbl_d[qry_list_id];
   end

   // any valid stage means an insert is in flight
   always_comb begin
      busy = 1'b0;
      for (int unsigned k = 1; k <= SN_LAT; k++) busy = busy | tag_q[k].vld;
   end

   // state registers; reset drops all tags so late sorter results are ignored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned l = 0; l < N_LISTS; l++) tbl_q[l] <= '0;
         tag_q            <= '0;
         qry_resp_valid_q <= 1'b0;
         qry_resp_q       <= '0;
      end else begin
         tbl_q            <= tbl_d;
         tag_q            <= tag_d;
         qry_resp_valid_q <= qry_resp_valid_d;
         qry_resp_q       <= qry_resp_d;
      end
   end

   assign qry_resp_valid = qry_resp_valid_q;
   assign qry_resp       = qry_resp_q;

endmodule

// File: tb/tb_sorted_list_scheduler.sv
// Bench for sorted_list_scheduler with a behavioural 3-cycle sorting network.
module tb_sorted_list_scheduler;
   import sorted_lists_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic     [N_REQ-1:0] req_valid = '0;
   logic     [N_REQ-1:0] req_ready;
   list_id_t [N_REQ-1:0] req_list_id = '0;
   entry_t   [N_REQ-1:0] req_entry = '0;
   logic                 sn_unsorted_valid;
   table_state_t         sn_unsorted, sn_sorted_r;
   logic                 qry_valid = 1'b0;
   list_id_t             qry_list_id = '0;
   logic                 qry_resp_valid;
   table_state_t         qry_resp;
   logic                 busy;

   always #5 clk = ~clk;

   sorted_list_scheduler dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_list_id       (req_list_id),
      .req_entry         (req_entry),
      .sn_unsorted_valid (sn_unsorted_valid),
      .sn_unsorted       (sn_unsorted),
      .sn_sorted_r       (sn_sorted_r),
      .qry_valid         (qry_valid),
      .qry_list_id       (qry_list_id),
      .qry_resp_valid    (qry_resp_valid),
      .qry_resp          (qry_resp),
      .busy              (busy)
   );

   // stable descending insertion sort
   function automatic table_state_t sort_ts(table_state_t t);
      entry_t tmp;
      for (int i = 1; i < 4; i++)
         for (int j = i; j > 0; j--)
            if (t.e[j-1].key < t.e[j].key) begin
               tmp = t.e[j]; t.e[j] = t.e[j-1]; t.e[j-1] = tmp;
            end
      return t;
   endfunction

   function automatic entry_t mk(logic [7:0] k);
      entry_t e;
      e.key = k;
      e.value = (k == 8'd0) ? 8'd0 : (k ^ 8'h5A);
      return e;
   endfunction

   function automatic table_state_t mk_ts(logic [7:0] k0, logic [7:0] k1, logic [7:0] k2, logic [7:0] k3);
      table_state_t t;
      t.e[0] = mk(k0); t.e[1] = mk(k1); t.e[2] = mk(k2); t.e[3] = mk(k3);
      return t;
   endfunction

   // sorting network model: result appears SN_LAT cycles after issue
   table_state_t sn_p1 = '0, sn_p2 = '0, sn_p3 = '0;
   always @(posedge clk) begin
      sn_p1 <= sort_ts(sn_unsorted);
      sn_p2 <= sn_p1;
      sn_p3 <= sn_p2;
   end
   assign sn_sorted_r = sn_p3;

   int unsigned  n_tests = 0, n_fail = 0;
   table_state_t model [N_LISTS];
   table_state_t q_exp [$];
   logic         exp_qv = 1'b0;
   logic         busy_s = 1'b0;
   table_state_t last_resp = '0, last_uns = '0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // one clock cycle: inputs already driven in the low phase; sample, check, advance
   task automatic cycle(output logic [N_REQ-1:0] acc);
      table_state_t e, u;
      int g;
      #1;
      busy_s = busy;
      chk("qry_resp_valid", 64'(qry_resp_valid), 64'(exp_qv));
      if (qry_resp_valid) begin
         if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            chk("qry_resp", 64'(qry_resp), 64'(e));
         end else chk("qry_resp_unexpected", 64'(1), 64'(0));
         last_resp = qry_resp;
      end
      exp_qv = qry_valid && !rst;
      if (qry_valid && !rst) q_exp.push_back(model[qry_list_id]);
      acc = req_valid & req_ready;
      chk("ready_onehot0", 64'($onehot0(req_ready)), 64'(1));
      chk("ready_without_valid", 64'(req_ready & ~req_valid), 64'(0));
      if (acc != '0) begin
         g = 0;
         for (int i = 0; i < N_REQ; i++) if (acc[i]) g = i;
         u = model[req_list_id[g]];
         if (req_entry[g].key > u.e[3].key) u.e[3] = req_entry[g];
         chk("sn_valid_on_issue", 64'(sn_unsorted_valid), 64'(1));
         chk("sn_unsorted", 64'(sn_unsorted), 64'(u));
         last_uns = sn_unsorted;
         model[req_list_id[g]] = sort_ts(u);
      end else begin
         chk("sn_valid_idle", 64'(sn_unsorted_valid), 64'(0));
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(int n);
      logic [N_REQ-1:0] acc;
      repeat (n) cycle(acc);
   endtask

   task automatic insert(int r, int id, logic [7:0] k);
      logic [N_REQ-1:0] acc;
      bit done;
      done = 0;
      req_valid[r] = 1'b1;
      req_list_id[r] = list_id_t'(id);
      req_entry[r] = mk(k);
      for (int c = 0; c < 20 && !done; c++) begin
         cycle(acc);
         if (acc[r]) done = 1;
      end
      req_valid[r] = 1'b0;
      chk("insert_accepted", 64'(done), 64'(1));
   endtask

   task automatic query(int id);
      logic [N_REQ-1:0] acc;
      qry_valid = 1'b1;
      qry_list_id = list_id_t'(id);
      cycle(acc);
      qry_valid = 1'b0;
   endtask

   task automatic model_clear();
      for (int l = 0; l < N_LISTS; l++) model[l] = '0;
      q_exp.delete();
      exp_qv = 1'b0;
   endtask

   typedef struct {
      int          list;
      logic [7:0]  key;
      logic [31:0] exp_keys;
   } vec_t;
   vec_t vecs [7];

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [N_REQ-1:0] acc;
      int waited;
      bit done;

      vecs[0] = '{0, 8'd5, {8'd5, 8'd0, 8'd0, 8'd0}};
      vecs[1] = '{1, 8'd3, {8'd3, 8'd0, 8'd0, 8'd0}};
      vecs[2] = '{1, 8'd9, {8'd9, 8'd3, 8'd0, 8'd0}};
      vecs[3] = '{1, 8'd1, {8'd9, 8'd3, 8'd1, 8'd0}};
      vecs[4] = '{1, 8'd7, {8'd9, 8'd7, 8'd3, 8'd1}};
      vecs[5] = '{1, 8'd2, {8'd9, 8'd7, 8'd3, 8'd2}};
      vecs[6] = '{1, 8'd0, {8'd9, 8'd7, 8'd3, 8'd2}};

      // reset state, with requests pending to prove ready stays low
      model_clear();
      req_valid = '1;
      @(negedge clk);
      #1;
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_sn_valid", 64'(sn_unsorted_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_qry_valid", 64'(qry_resp_valid), 64'(0));
      chk("rst_qry_resp", 64'(qry_resp), 64'(0));
      @(negedge clk);
      req_valid = '0;
      rst = 1'b0;

      // table-driven inserts, each read back once its writeback has landed
      for (int v = 0; v < 7; v++) begin
         insert(0, vecs[v].list, vecs[v].key);
         if (v == 0) chk("first_e3_key", 64'(last_uns.e[3].key), 64'(8'd5));
         idle(3);
         query(vecs[v].list);
         idle(1);
         chk("vec_keys", 64'({last_resp.e[0].key, last_resp.e[1].key,
                              last_resp.e[2].key, last_resp.e[3].key}), 64'(vecs[v].exp_keys));
      end

      // query in the writeback cycle sees the post-sort contents
      insert(0, 3, 8'd40);
      idle(2);
      query(3);
      idle(1);
      chk("bypass", 64'(last_resp), 64'(mk_ts(8'd40, 8'd0, 8'd0, 8'd0)));

      // reset two cycles after an issue: no writeback, everything clears
      insert(0, 3, 8'd50);
      idle(1);
      rst = 1'b1;
      req_valid = '1;
      req_list_id[0] = list_id_t'(0);
      req_list_id[1] = list_id_t'(1);
      req_entry[0] = mk(8'd11);
      req_entry[1] = mk(8'd12);
      #1;
      chk("midrst_ready", 64'(req_ready), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_qry_resp", 64'(qry_resp), 64'(0));
      model_clear();
      idle(2);
      rst = 1'b0;
      req_valid = '0;
      idle(4);
      chk("midrst_busy_after", 64'(busy_s), 64'(0));
      for (int l = 0; l < N_LISTS; l++) query(l);
      idle(1);
      chk("midrst_list3_zero", 64'(last_resp), 64'(0));

      // two requesters on the same list: second waits out the hazard window
      req_valid = '1;
      req_list_id[0] = list_id_t'(2);
      req_list_id[1] = list_id_t'(2);
      req_entry[0] = mk(8'd20);
      req_entry[1] = mk(8'd30);
      cycle(acc);
      chk("hazard_first_grant", 64'(acc), 64'(2'b01));
      req_valid[0] = 1'b0;
      waited = 0;
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         cycle(acc);
         waited++;
         if (acc[1]) done = 1;
      end
      req_valid[1] = 1'b0;
      chk("hazard_delay", 64'(waited), 64'(4));
      idle(3);
      query(2);
      idle(1);
      chk("hazard_final", 64'(last_resp), 64'(mk_ts(8'd30, 8'd20, 8'd0, 8'd0)));

      // fairness: both requesters always valid, each alternating between two lists
      req_valid = '1;
      req_list_id[0] = list_id_t'(0);
      req_list_id[1] = list_id_t'(1);
      req_entry[0] = mk(8'($urandom_range(1, 255)));
      req_entry[1] = mk(8'($urandom_range(1, 255)));
      for (int i = 0; i < 8; i++) begin
         cycle(acc);
         chk("fair_grant", 64'(acc), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
         if (i > 0) chk("fair_busy", 64'(busy_s), 64'(1));
         for (int r = 0; r < N_REQ; r++) begin
            if (acc[r]) begin
               req_list_id[r] = req_list_id[r] ^ list_id_t'(2);
               req_entry[r] = mk(8'($urandom_range(1, 255)));
            end
         end
      end
      req_valid = '0;
      idle(4);
      chk("drain_busy", 64'(busy_s), 64'(0));
      for (int l = 0; l < N_LISTS; l++) query(l);
      idle(1);
      chk("queries_drained", 64'(q_exp.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
